// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU each take one bit per cycle through a shared 64-bit
// working register. A final fix-up cycle applies the result signs and writes hi/lo.
// Optional build macro MULDIV_FAST_MUL_EN: multiply uses a single-cycle
// 64-bit product and skips the iteration phase. Divide timing is unchanged.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [DW-1:0]    acc_q, acc_d;       // mul: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0] opnd_q, opnd_d;     // mul: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0] a_q, a_d;           // original dividend for divide-by-zero
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bzero_q, bzero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [DW-1:0]    acc_neg;
  logic [WIDTH-1:0] quo_neg, rem_neg;

  // Operand magnitudes and per-iteration arithmetic
  assign abs_a     = (sign && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign abs_b     = (sign && b[WIDTH-1]) ? WIDTH'(-b) : b;
  assign mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_trial = acc_q[DW-1:WIDTH-1] - {1'b0, opnd_q};
  assign acc_neg   = DW'(-acc_q);
  assign quo_neg   = WIDTH'(-acc_q[WIDTH-1:0]);
  assign rem_neg   = WIDTH'(-acc_q[DW-1:WIDTH]);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = a;
        if (wr_lo) lo_d = a;
        if (start && !cancel) begin
          busy_d    = 1'b1;
          div_d     = op_div;
          a_d       = a;
          bzero_d   = (b == '0);
          neg_res_d = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = sign && a[WIDTH-1];
          cnt_d     = '0;
          if (op_div) begin
            opnd_d  = abs_b;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            state_d = CALC;
          end else begin
            opnd_d  = abs_a;
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = DW'(abs_a) * DW'(abs_b);
            state_d = FIX;
`else
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        if (div_q) begin
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[DW-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        if (!div_q) begin
          hi_d = neg_res_q ? acc_neg[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
          lo_d = neg_res_q ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = neg_rem_q ? rem_neg : acc_q[DW-1:WIDTH];
          lo_d = neg_res_q ? quo_neg : acc_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Flush: drop the op in flight without touching hi/lo
    if (cancel) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      if (state_q != IDLE) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
